// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the multi-channel timer.
//   - Control register bit indices (START, DONE, MODE, IRQ_EN, PRESC field)
//   - timer_mode_e: one-shot or auto-reload
//   - timer_ctrl_t: per-channel control register image
//   - ctrl_word(): packs a control image into the 32-bit read layout
// The PRESC field is stored 8 bits wide (the maximum). A channel masks it to
// its own PRESC_W on write, so the unused upper bits always read as 0.
package timer_pkg;

  localparam int CTRL_START     = 0;
  localparam int CTRL_DONE      = 1;
  localparam int CTRL_MODE      = 2;
  localparam int CTRL_IRQEN     = 3;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int PRESC_MAX_W    = 8;

  typedef enum logic {
    ONE_SHOT    = 1'b0,
    AUTO_RELOAD = 1'b1
  } timer_mode_e;

  typedef struct packed {
    logic [PRESC_MAX_W-1:0] presc;
    logic                   irq_en;
    timer_mode_e            mode;
    logic                   done;
    logic                   start;
  } timer_ctrl_t;

  function automatic logic [31:0] ctrl_word(input timer_ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_START] = c.start;
    w[CTRL_DONE]  = c.done;
    w[CTRL_MODE]  = c.mode;
    w[CTRL_IRQEN] = c.irq_en;
    w[CTRL_PRESC_LSB +: PRESC_MAX_W] = c.presc;
    return w;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer channel (control, target, prescaler, counter,
// compare).
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   wr_ctrl        write wr_data into the control register this edge
//   wr_tgt         write wr_data[WIDTH-1:0] into the target register
//   wr_data        32-bit write data
//   ctrl_rd        control register in 32-bit read layout
//   target_rd      target register
//   count_rd       live count
//   done_irq       DONE & IRQ_EN
//   pwm            (only with TIMER_PWM_EN) START & (count < target/2), registered
// Write strobes are single-cycle and always accepted; there is no back-pressure.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ctrl,
  input  logic             wr_tgt,
  input  logic [31:0]      wr_data,
  output logic [31:0]      ctrl_rd,
  output logic [WIDTH-1:0] target_rd,
  output logic [WIDTH-1:0] count_rd,
  output logic             done_irq
`ifdef TIMER_PWM_EN
  ,
  output logic             pwm
`endif
);

  timer_ctrl_t          ctrl_q;
  logic [WIDTH-1:0]     target_q;
  logic [WIDTH-1:0]     count_q;
  logic [PRESC_W-1:0]   psc_q;

  logic [PRESC_W-1:0]   presc_cur;
  logic [WIDTH-1:0]     eff_target;
  logic [WIDTH-1:0]     count_inc;
  logic                 tick;
  logic                 hit;
  logic                 wr_start;
  logic                 starting;
  logic                 stopping;

  always_comb begin
    presc_cur  = ctrl_q.presc[PRESC_W-1:0];
    // >= rather than == so a PRESC lowered below the running prescaler count
    // ticks at once instead of waiting for the counter to wrap.
    tick       = ctrl_q.start && (psc_q >= presc_cur);
    eff_target = (target_q == '0) ? WIDTH'(1) : target_q;
    count_inc  = count_q + WIDTH'(1);
    hit        = tick && (count_inc >= eff_target);
    wr_start   = wr_data[CTRL_START];
    starting   = wr_ctrl && wr_start && !ctrl_q.start;
    stopping   = wr_ctrl && !wr_start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= '0;
      target_q <= '0;
      count_q  <= '0;
      psc_q    <= '0;
    end else begin
      if (wr_tgt) target_q <= wr_data[WIDTH-1:0];

      if (wr_ctrl) begin
        ctrl_q.start  <= wr_start;
        ctrl_q.mode   <= timer_mode_e'(wr_data[CTRL_MODE]);
        ctrl_q.irq_en <= wr_data[CTRL_IRQEN];
        ctrl_q.presc  <= PRESC_MAX_W'(wr_data[CTRL_PRESC_LSB +: PRESC_W]);
        if (wr_data[CTRL_DONE]) ctrl_q.done <= 1'b0;
      end

      if (starting) begin
        count_q     <= '0;
        psc_q       <= '0;
        ctrl_q.done <= 1'b0;
      end else if (ctrl_q.start && !stopping) begin
        psc_q <= tick ? '0 : psc_q + PRESC_W'(1);
        if (hit) begin
          // Placed after the W1C handling so a same-edge set wins.
          ctrl_q.done <= 1'b1;
          if (ctrl_q.mode == AUTO_RELOAD) begin
            count_q <= '0;
          end else begin
            count_q      <= count_inc;
            ctrl_q.start <= 1'b0;
          end
        end else if (tick) begin
          count_q <= count_inc;
        end
      end
    end
  end

`ifdef TIMER_PWM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm <= 1'b0;
    else      pwm <= ctrl_q.start && (count_q < (target_q >> 1));
  end
`endif

  assign ctrl_rd   = ctrl_word(ctrl_q);
  assign target_rd = target_q;
  assign count_rd  = count_q;
  assign done_irq  = ctrl_q.done && ctrl_q.irq_en;

  // Only some write-data bits land in registers; the rest are don't-care.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data;

endmodule

// File: rtl/timer_multi_module.sv
// timer_multi_module: N_CH independent up-counting timers behind one register
// interface addressed by ch_sel.
// Optional feature: define TIMER_PWM_EN to add pwm_out[N_CH].
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ch_sel                   channel addressed by reads and writes
//   wr_ctrl_en / wr_data_en  write control / target of ch_sel from wr_data
//   rd_ctrl_en / rd_data_en / rd_cnt_en   combinational reads of ch_sel
//   rd_ctrl_data / rd_data_data / rd_cnt_data  read data (0 when not enabled
//                            or when ch_sel >= N_CH)
//   timer_done               per-channel DONE & IRQ_EN
//   irq                      OR of timer_done
module timer_multi_module
  import timer_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8,
  localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic             wr_ctrl_en,
  input  logic             wr_data_en,
  input  logic [31:0]      wr_data,
  input  logic             rd_ctrl_en,
  input  logic             rd_data_en,
  input  logic             rd_cnt_en,
  output logic [31:0]      rd_ctrl_data,
  output logic [31:0]      rd_data_data,
  output logic [31:0]      rd_cnt_data,
  output logic [N_CH-1:0]  timer_done,
  output logic             irq
`ifdef TIMER_PWM_EN
  ,
  output logic [N_CH-1:0]  pwm_out
`endif
);

  logic [31:0]      ctrl_w [N_CH];
  logic [WIDTH-1:0] tgt_w  [N_CH];
  logic [WIDTH-1:0] cnt_w  [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit_sel;
    assign hit_sel = (ch_sel == SEL_W'(i));

    timer_channel #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_ctrl   (wr_ctrl_en && hit_sel),
      .wr_tgt    (wr_data_en && hit_sel),
      .wr_data   (wr_data),
      .ctrl_rd   (ctrl_w[i]),
      .target_rd (tgt_w[i]),
      .count_rd  (cnt_w[i]),
      .done_irq  (timer_done[i])
`ifdef TIMER_PWM_EN
      ,
      .pwm       (pwm_out[i])
`endif
    );
  end

  // Out-of-range selects match no channel, so reads fall through to 0.
  always_comb begin
    rd_ctrl_data = '0;
    rd_data_data = '0;
    rd_cnt_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == SEL_W'(i)) begin
        if (rd_ctrl_en) rd_ctrl_data = ctrl_w[i];
        if (rd_data_en) rd_data_data = 32'(tgt_w[i]);
        if (rd_cnt_en)  rd_cnt_data  = 32'(cnt_w[i]);
      end
    end
  end

  assign irq = |timer_done;

endmodule
